matrix_vector_mac: RTL

Parametrised, sequential successor to the team's fixed 3x3 combinational matrix-by-vector block. It computes C = A x B for a DIM x DIM matrix A and a DIM x 1 vector B using one shared multiply-accumulate unit. Operands arrive over a valid/ready input stream and results leave over a valid/ready output stream. It sits between the operand buffer and the result sink in the matrix datapath, and supports signed or unsigned operands and reuse of a previously loaded vector.

---
 rtl/matrix_vector_mac.sv | 98 +++++++++
 1 files changed

// File: rtl/matrix_vector_mac.sv
// matrix_vector_mac: sequential C = A x B using one shared MAC, valid/ready streams in and out
module matrix_vector_mac #(
  parameter int NBITS        = 16,
  parameter int DIM          = 3,
  parameter int RESULT_WIDTH = 2*NBITS+$clog2(DIM)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 reuse_vec,
  input  logic                                 signed_mode,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NBITS-1:0]                     in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [RESULT_WIDTH-1:0]              out_data,
  output logic [(DIM>1 ? $clog2(DIM) : 1)-1:0] out_row,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 done
);
  localparam int CW = DIM > 1 ? $clog2(DIM) : 1;
  localparam logic [1:0] IDLE = 2'd0, LOAD_B = 2'd1, MAC = 2'd2, EMIT = 2'd3;
  localparam logic [CW-1:0] LAST = CW'(DIM-1);

  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           col_q, col_d, row_q, row_d;
  logic [RESULT_WIDTH-1:0] acc_q, acc_d;
  logic [NBITS-1:0]        b_q [DIM];
  logic [NBITS-1:0]        b_d [DIM];
  logic                    sgn_q, sgn_d, done_q, done_d;

  function automatic logic [RESULT_WIDTH-1:0] ext(input logic [NBITS-1:0] x, input logic s);
    return {{(RESULT_WIDTH-NBITS){s & x[NBITS-1]}}, x};
  endfunction

  assign in_ready  = state_q == LOAD_B || state_q == MAC;
  assign out_valid = state_q == EMIT;
  assign out_data  = acc_q;
  assign out_row   = row_q;
  assign out_last  = out_valid && row_q == LAST;
  assign busy      = state_q != IDLE;
  assign done      = done_q;

  // next-state: vector load, per-row accumulate, then hold the result until accepted
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    acc_d   = acc_q;
    sgn_d   = sgn_q;
    b_d     = b_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        sgn_d   = signed_mode;
        state_d = reuse_vec ? MAC : LOAD_B;
      end
      LOAD_B: if (in_valid) begin
        b_d[col_q] = in_data;
        col_d      = col_q == LAST ? '0 : col_q + 1'b1;
        state_d    = col_q == LAST ? MAC : LOAD_B;
      end
      MAC: if (in_valid) begin
        acc_d   = (col_q == '0 ? '0 : acc_q) + ext(in_data, sgn_q) * ext(b_q[col_q], sgn_q);
        col_d   = col_q == LAST ? '0 : col_q + 1'b1;
        state_d = col_q == LAST ? EMIT : MAC;
      end
      default: if (out_ready) begin
        row_d   = row_q == LAST ? '0 : row_q + 1'b1;
        state_d = row_q == LAST ? IDLE : MAC;
        done_d  = row_q == LAST;
      end
    endcase
  end

  // state registers; reset also clears the stored vector so a later reuse sees B=0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      acc_q   <= '0;
      sgn_q   <= 1'b0;
      done_q  <= 1'b0;
      b_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
      sgn_q   <= sgn_d;
      done_q  <= done_d;
      b_q     <= b_d;
    end
  end
endmodule
